// File: rtl/slot_alloc.sv
// slot_alloc: registered free-slot allocator.
// Keeps a W-bit occupancy vector and offers one free slot per cycle over a
// valid/ready handshake, accepting one release per cycle. The next offered
// slot is precomputed from the post-update state, so every output is a flop.
module slot_alloc #(
    parameter int W        = 16,
    parameter int NEXT_FIT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_alloc_vld,
    output logic                   o_alloc_rdy,
    output logic [$clog2(W)-1:0]   o_alloc_idx,
    input  logic                   i_free_vld,
    input  logic [$clog2(W)-1:0]   i_free_idx,
    output logic [W-1:0]           o_occ,
    output logic [$clog2(W+1)-1:0] o_cnt,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_err_dfree
);

    localparam int LW = $clog2(W);
    localparam int CW = $clog2(W+1);

    logic [LW-1:0] ptr;

    logic          grant;
    logic          free_hit;
    logic          dfree;
    logic [W-1:0]  grant_mask;
    logic [W-1:0]  free_mask;
    logic [W-1:0]  occ_next;
    logic [CW-1:0] cnt_next;
    logic [LW-1:0] ptr_next;
    logic [LW-1:0] idx_next;

    // First zero of v: circularly downward from p-1 (next-fit) or lowest index.
    // When v has no zero the previous offer is held; it is a don't-care then.
    function automatic logic [LW-1:0] search(input logic [W-1:0]  v,
                                             input logic [LW-1:0] p,
                                             input logic [LW-1:0] hold);
        logic [LW-1:0] r;
        logic [LW-1:0] c;
        r = hold;
        c = '0;
        if (NEXT_FIT != 0) begin
            // Walk farthest-first so the nearest candidate (p-1) wins last.
            for (int i = W; i >= 1; i--) begin
                c = p - LW'(i);
                if (!v[c]) r = c;
            end
        end else begin
            for (int i = W-1; i >= 0; i--) begin
                if (!v[LW'(i)]) r = LW'(i);
            end
        end
        return r;
    endfunction

    // Next-state: apply grant and release together, then look ahead for the next offer.
    always_comb begin
        grant      = i_alloc_vld && o_alloc_rdy;
        // A release of the slot being granted sees it as free: that is a double-free.
        free_hit   = i_free_vld && o_occ[i_free_idx];
        dfree      = i_free_vld && !o_occ[i_free_idx];
        grant_mask = grant    ? (W'(1) << o_alloc_idx) : '0;
        free_mask  = free_hit ? (W'(1) << i_free_idx)  : '0;
        occ_next   = (o_occ | grant_mask) & ~free_mask;
        cnt_next   = o_cnt + CW'(grant) - CW'(free_hit);
        ptr_next   = ((NEXT_FIT != 0) && grant) ? o_alloc_idx : ptr;
        idx_next   = search(occ_next, ptr_next, o_alloc_idx);
    end

    // State and registered outputs; reset wins over any concurrent request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_occ       <= '0;
            ptr         <= '0;
            o_cnt       <= '0;
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_alloc_rdy <= 1'b1;
            o_err_dfree <= 1'b0;
            o_alloc_idx <= (NEXT_FIT != 0) ? LW'(W-1) : '0;
        end else begin
            o_occ       <= occ_next;
            ptr         <= ptr_next;
            o_cnt       <= cnt_next;
            o_full      <= (cnt_next == CW'(W));
            o_empty     <= (cnt_next == '0);
            o_alloc_rdy <= ~&occ_next;
            o_err_dfree <= dfree;
            o_alloc_idx <= idx_next;
        end
    end

endmodule

// File: tb/tb_slot_alloc.sv
// tb_slot_alloc: directed scoreboard bench for slot_alloc, one instance per
// allocation order. Expected grant indices are queued by the stimulus and
// popped by per-instance monitors whenever a handshake completes.
module tb_slot_alloc;

    logic        clk;
    logic        rst;

    logic        nf_vld, nf_rdy, nf_fvld, nf_full, nf_empty, nf_err;
    logic [3:0]  nf_idx, nf_fidx;
    logic [15:0] nf_occ;
    logic [4:0]  nf_cnt;

    logic        lf_vld, lf_rdy, lf_fvld, lf_full, lf_empty, lf_err;
    logic [3:0]  lf_idx, lf_fidx;
    logic [15:0] lf_occ;
    logic [4:0]  lf_cnt;

    int checks = 0;
    int errors = 0;

    int q_nf[$];
    int q_lf[$];

    slot_alloc #(.W(16), .NEXT_FIT(1)) dut_nf (
        .i_clk(clk), .i_rst(rst),
        .i_alloc_vld(nf_vld), .o_alloc_rdy(nf_rdy), .o_alloc_idx(nf_idx),
        .i_free_vld(nf_fvld), .i_free_idx(nf_fidx),
        .o_occ(nf_occ), .o_cnt(nf_cnt), .o_full(nf_full), .o_empty(nf_empty),
        .o_err_dfree(nf_err)
    );

    slot_alloc #(.W(16), .NEXT_FIT(0)) dut_lf (
        .i_clk(clk), .i_rst(rst),
        .i_alloc_vld(lf_vld), .o_alloc_rdy(lf_rdy), .o_alloc_idx(lf_idx),
        .i_free_vld(lf_fvld), .i_free_idx(lf_fidx),
        .o_occ(lf_occ), .o_cnt(lf_cnt), .o_full(lf_full), .o_empty(lf_empty),
        .o_err_dfree(lf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are read 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push_nf_range(input int hi, input int lo);
        for (int k = hi; k >= lo; k--) q_nf.push_back(k);
    endtask

    task automatic chk_nf_reset(input string tag);
        chk({tag, "_occ"},   nf_occ,   32'h0);
        chk({tag, "_cnt"},   nf_cnt,   32'd0);
        chk({tag, "_empty"}, nf_empty, 32'd1);
        chk({tag, "_full"},  nf_full,  32'd0);
        chk({tag, "_rdy"},   nf_rdy,   32'd1);
        chk({tag, "_idx"},   nf_idx,   32'd15);
        chk({tag, "_err"},   nf_err,   32'd0);
    endtask

    // Next-fit monitor: a handshake seen mid-cycle is the grant of the coming edge.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst && nf_vld && nf_rdy) begin
                if (q_nf.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL nf_grant: got unexpected grant %0d expected none", nf_idx);
                end else begin
                    e = q_nf.pop_front();
                    chk("nf_grant", nf_idx, e);
                end
            end
        end
    end

    // Lowest-first monitor.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst && lf_vld && lf_rdy) begin
                if (q_lf.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lf_grant: got unexpected grant %0d expected none", lf_idx);
                end else begin
                    e = q_lf.pop_front();
                    chk("lf_grant", lf_idx, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        nf_vld = 0; nf_fvld = 0; nf_fidx = 0;
        lf_vld = 0; lf_fvld = 0; lf_fidx = 0;

        // Reset values
        repeat (2) cyc();
        rst = 1'b0;
        chk_nf_reset("rst");
        chk("lf_rst_idx", lf_idx, 32'd0);

        // Fill and wrap: grants 15 down to 0
        push_nf_range(15, 0);
        nf_vld = 1;
        repeat (16) cyc();
        chk("fill_full", nf_full, 32'd1);
        chk("fill_rdy",  nf_rdy,  32'd0);
        chk("fill_cnt",  nf_cnt,  32'd16);
        chk("fill_occ",  nf_occ,  32'hFFFF);
        // Free 9 while full with the request still held
        nf_fvld = 1; nf_fidx = 4'd9;
        q_nf.push_back(9);
        cyc();
        nf_fvld = 0;
        chk("free_full_rdy", nf_rdy, 32'd1);
        chk("free_full_cnt", nf_cnt, 32'd15);
        cyc();
        nf_vld = 0;
        chk("refill_full", nf_full, 32'd1);
        chk("refill_cnt",  nf_cnt,  32'd16);

        // Next-fit search from pointer
        rst = 1; cyc(); rst = 0;
        push_nf_range(15, 10);
        nf_vld = 1;
        repeat (6) cyc();
        nf_vld = 0;
        chk("nf6_occ", nf_occ, 32'hFC00);
        nf_fvld = 1; nf_fidx = 4'd12;
        cyc();
        nf_fvld = 0;
        chk("nf_free12_occ", nf_occ, 32'hEC00);
        chk("nf_free12_idx", nf_idx, 32'd9);
        push_nf_range(9, 0);
        q_nf.push_back(12);
        nf_vld = 1;
        repeat (11) cyc();
        nf_vld = 0;
        chk("nf_wrap_full", nf_full, 32'd1);
        chk("nf_wrap_occ",  nf_occ,  32'hFFFF);

        // Double-free of an unallocated slot
        rst = 1; cyc(); rst = 0;
        nf_fvld = 1; nf_fidx = 4'd5;
        cyc();
        nf_fvld = 0;
        chk("dfree_err", nf_err, 32'd1);
        chk("dfree_occ", nf_occ, 32'h0);
        chk("dfree_cnt", nf_cnt, 32'd0);
        cyc();
        chk("dfree_err_drop", nf_err, 32'd0);

        // Same-cycle grant and free of the granted slot 7
        push_nf_range(15, 8);
        nf_vld = 1;
        repeat (8) cyc();
        chk("pre7_idx", nf_idx, 32'd7);
        nf_fvld = 1; nf_fidx = 4'd7;
        q_nf.push_back(7);
        cyc();
        chk("same7_occ", nf_occ, 32'hFF80);
        chk("same7_cnt", nf_cnt, 32'd9);
        chk("same7_err", nf_err, 32'd1);
        // Same-cycle grant of 6 and valid free of 15
        nf_fidx = 4'd15;
        q_nf.push_back(6);
        cyc();
        nf_vld = 0; nf_fvld = 0;
        chk("swap_occ", nf_occ, 32'h7FC0);
        chk("swap_cnt", nf_cnt, 32'd9);
        chk("swap_err", nf_err, 32'd0);
        chk("swap_idx", nf_idx, 32'd5);

        // Mid-operation reset with 11 allocated and both requests active
        push_nf_range(5, 4);
        nf_vld = 1;
        repeat (2) cyc();
        chk("mid_cnt", nf_cnt, 32'd11);
        rst = 1; nf_fvld = 1; nf_fidx = 4'd3;
        cyc();
        rst = 0; nf_vld = 0; nf_fvld = 0;
        chk_nf_reset("midrst");

        // Lowest-first order
        q_lf.push_back(0); q_lf.push_back(1); q_lf.push_back(2); q_lf.push_back(3);
        lf_vld = 1;
        repeat (4) cyc();
        lf_vld = 0;
        chk("lf4_occ", lf_occ, 32'h000F);
        lf_fvld = 1; lf_fidx = 4'd1;
        cyc();
        lf_fidx = 4'd3;
        cyc();
        lf_fvld = 0;
        chk("lf_free_occ", lf_occ, 32'h0005);
        chk("lf_free_idx", lf_idx, 32'd1);
        q_lf.push_back(1); q_lf.push_back(3);
        lf_vld = 1;
        repeat (2) cyc();
        lf_vld = 0;
        chk("lf_end_occ", lf_occ, 32'h000F);
        chk("lf_end_cnt", lf_cnt, 32'd4);
        chk("lf_end_idx", lf_idx, 32'd4);

        // Every queued grant must have been observed
        cyc();
        chk("nf_queue_left", q_nf.size(), 32'd0);
        chk("lf_queue_left", q_lf.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
